// File: rtl/rvh_noc_pkg.sv
// Shared NoC link types: decoded flit control and the widest VC id carried
// on the credit return path.
package rvh_noc_pkg;

    localparam int VC_ID_NUM_MAX_W = 2;

    typedef struct packed {
        logic       head;
        logic       tail;
        logic [5:0] tgt_id;
    } flit_dec_t;

endpackage

// File: rtl/vc_credit_counter.sv
// One downstream VC credit counter: returns add, sends subtract, the count
// saturates at DEPTH and flags an over-return.
module vc_credit_counter #(
    parameter int DEPTH = 1,
    parameter int W     = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] FULL = W'(DEPTH);

    assign ovf = inc && !dec && (cnt == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= FULL;
        end else if (inc && !dec && (cnt != FULL)) begin
            cnt <= cnt + W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/output_port_vc_tx.sv
// Output port transmitter: credit-gated flit send onto the link with one
// registered stage and per-VC credit tracking.
module output_port_vc_tx
    import rvh_noc_pkg::*;
#(
    parameter type flit_payload_t = logic [256-1:0],
    parameter int  VC_NUM         = 1,
    parameter int  VC_NUM_IDX_W   = VC_NUM > 1 ? $clog2(VC_NUM) : 1,
    parameter int  VC_DEPTH       = 1,
    parameter int  CRD_W          = $clog2(VC_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            send_vld_i,
    input  flit_payload_t                   send_payload_i,
    input  flit_dec_t                       send_dec_i,
    input  logic [VC_NUM_IDX_W-1:0]         send_vc_id_i,
    output logic                            send_rdy_o,
    output logic                            flit_v_o,
    output flit_payload_t                   flit_o,
    output flit_dec_t                       flit_dec_o,
    output logic [VC_NUM_IDX_W-1:0]         flit_vc_id_o,
    input  logic                            lcrd_v_i,
    input  logic [VC_ID_NUM_MAX_W-1:0]      lcrd_id_i,
    output logic [VC_NUM-1:0]               vc_crd_avail_o,
    output logic [VC_NUM-1:0][CRD_W-1:0]    vc_crd_cnt_o,
    output logic                            all_crd_home_o,
    output logic                            crd_err_o
);

    logic [VC_NUM-1:0] inc;
    logic [VC_NUM-1:0] dec;
    logic [VC_NUM-1:0] ovf;
    logic [VC_NUM-1:0] home;
    logic              fire;
    logic              bad_id;

    // Matching by loop keeps out-of-range VC ids from indexing the array.
    always_comb begin
        send_rdy_o = 1'b0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (send_vc_id_i == VC_NUM_IDX_W'(v) && vc_crd_cnt_o[v] != '0) begin
                send_rdy_o = 1'b1;
            end
        end
    end

    assign fire   = send_vld_i && send_rdy_o;
    assign bad_id = lcrd_v_i && ~|inc;

    for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
        assign inc[g] = lcrd_v_i && (lcrd_id_i == VC_ID_NUM_MAX_W'(g));
        assign dec[g] = fire && (send_vc_id_i == VC_NUM_IDX_W'(g));

        vc_credit_counter #(
            .DEPTH (VC_DEPTH),
            .W     (CRD_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[g]),
            .dec (dec[g]),
            .cnt (vc_crd_cnt_o[g]),
            .ovf (ovf[g])
        );

        assign vc_crd_avail_o[g] = vc_crd_cnt_o[g] != '0;
        assign home[g]           = vc_crd_cnt_o[g] == CRD_W'(VC_DEPTH);
    end

    assign all_crd_home_o = &home;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_v_o     <= 1'b0;
            flit_o       <= '0;
            flit_dec_o   <= '0;
            flit_vc_id_o <= '0;
            crd_err_o    <= 1'b0;
        end else begin
            flit_v_o <= fire;
            if (fire) begin
                flit_o       <= send_payload_i;
                flit_dec_o   <= send_dec_i;
                flit_vc_id_o <= send_vc_id_i;
            end
            if (bad_id || |ovf) begin
                crd_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_port_vc_tx.sv
// Directed vector bench for output_port_vc_tx with two VCs of depth two.
module tb_output_port_vc_tx;
    import rvh_noc_pkg::*;

    typedef logic [255:0] pl_t;

    logic                       clk;
    logic                       rst;
    logic                       send_vld_i;
    pl_t                        send_payload_i;
    flit_dec_t                  send_dec_i;
    logic [0:0]                 send_vc_id_i;
    logic                       send_rdy_o;
    logic                       flit_v_o;
    pl_t                        flit_o;
    flit_dec_t                  flit_dec_o;
    logic [0:0]                 flit_vc_id_o;
    logic                       lcrd_v_i;
    logic [VC_ID_NUM_MAX_W-1:0] lcrd_id_i;
    logic [1:0]                 vc_crd_avail_o;
    logic [1:0][1:0]            vc_crd_cnt_o;
    logic                       all_crd_home_o;
    logic                       crd_err_o;

    output_port_vc_tx #(
        .flit_payload_t (pl_t),
        .VC_NUM         (2),
        .VC_DEPTH       (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .send_vld_i     (send_vld_i),
        .send_payload_i (send_payload_i),
        .send_dec_i     (send_dec_i),
        .send_vc_id_i   (send_vc_id_i),
        .send_rdy_o     (send_rdy_o),
        .flit_v_o       (flit_v_o),
        .flit_o         (flit_o),
        .flit_dec_o     (flit_dec_o),
        .flit_vc_id_o   (flit_vc_id_o),
        .lcrd_v_i       (lcrd_v_i),
        .lcrd_id_i      (lcrd_id_i),
        .vc_crd_avail_o (vc_crd_avail_o),
        .vc_crd_cnt_o   (vc_crd_cnt_o),
        .all_crd_home_o (all_crd_home_o),
        .crd_err_o      (crd_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       vc;
        pl_t        pl;
        logic       lv;
        logic [1:0] lid;
        logic       e_rdy;
        logic       e_fv;
        logic       e_vcid;
        logic [1:0] e_c0;
        logic [1:0] e_c1;
        logic       e_err;
    } vec_t;

    vec_t vt[10];
    int n_checks = 0;
    int n_errors = 0;
    pl_t       e_data;
    flit_dec_t e_dec;

    task automatic chk(input string nm, input pl_t act, input pl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        send_vld_i     = 1'b0;
        send_payload_i = '0;
        send_dec_i     = '0;
        send_vc_id_i   = 1'b0;
        lcrd_v_i       = 1'b0;
        lcrd_id_i      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_state(input string nm, input logic [1:0] c0,
                             input logic [1:0] c1, input logic err);
        chk({nm, ".cnt0"}, pl_t'(vc_crd_cnt_o[0]), pl_t'(c0));
        chk({nm, ".cnt1"}, pl_t'(vc_crd_cnt_o[1]), pl_t'(c1));
        chk({nm, ".err"}, pl_t'(crd_err_o), pl_t'(err));
        chk({nm, ".home"}, pl_t'(all_crd_home_o), pl_t'(c0 == 2 && c1 == 2));
        chk({nm, ".avail"}, pl_t'(vc_crd_avail_o),
            pl_t'({c1 != 0, c0 != 0}));
    endtask

    initial begin
        //       vld  vc  payload  lv  lid  rdy  fv  vcid c0 c1 err
        vt[0] = '{1, 0, 256'hA1, 0, 0, 1, 1, 0, 1, 2, 0};
        vt[1] = '{1, 0, 256'hB2, 0, 0, 1, 1, 0, 0, 2, 0};
        vt[2] = '{1, 0, 256'hC3, 0, 0, 0, 0, 0, 0, 2, 0};
        vt[3] = '{1, 0, 256'hD4, 1, 0, 0, 0, 0, 1, 2, 0};
        vt[4] = '{0, 0, 256'h0,  0, 0, 1, 0, 0, 1, 2, 0};
        vt[5] = '{1, 1, 256'hE5, 0, 0, 1, 1, 1, 1, 1, 0};
        vt[6] = '{1, 1, 256'hF6, 1, 1, 1, 1, 1, 1, 1, 0};
        vt[7] = '{0, 0, 256'h0,  1, 1, 1, 0, 1, 1, 2, 0};
        vt[8] = '{1, 0, {4{64'hDEAD_BEEF_0123_4567}}, 1, 1, 1, 1, 0, 0, 2, 1};
        vt[9] = '{0, 0, 256'h0,  0, 0, 0, 0, 0, 0, 2, 1};

        idle();
        do_reset();
        chk_state("reset", 2'd2, 2'd2, 1'b0);
        chk("reset.fv", pl_t'(flit_v_o), '0);
        chk("reset.data", flit_o, '0);
        e_data = '0;
        e_dec  = '0;

        for (int i = 0; i < 10; i++) begin
            send_vld_i     = vt[i].vld;
            send_vc_id_i   = vt[i].vc;
            send_payload_i = vt[i].pl;
            send_dec_i     = flit_dec_t'(8'(i + 1));
            lcrd_v_i       = vt[i].lv;
            lcrd_id_i      = vt[i].lid;
            #1;
            chk($sformatf("v%0d.rdy", i), pl_t'(send_rdy_o), pl_t'(vt[i].e_rdy));
            if (vt[i].e_fv) begin
                e_data = vt[i].pl;
                e_dec  = flit_dec_t'(8'(i + 1));
            end
            @(posedge clk);
            #1;
            idle();
            chk($sformatf("v%0d.fv", i), pl_t'(flit_v_o), pl_t'(vt[i].e_fv));
            chk($sformatf("v%0d.data", i), flit_o, e_data);
            chk($sformatf("v%0d.dec", i), pl_t'(flit_dec_o), pl_t'(e_dec));
            if (vt[i].e_fv)
                chk($sformatf("v%0d.vcid", i), pl_t'(flit_vc_id_o),
                    pl_t'(vt[i].e_vcid));
            chk_state($sformatf("v%0d", i), vt[i].e_c0, vt[i].e_c1, vt[i].e_err);
        end

        // Out-of-range credit id after a clean reset.
        do_reset();
        chk_state("rst2", 2'd2, 2'd2, 1'b0);
        lcrd_v_i  = 1'b1;
        lcrd_id_i = 2'd3;
        @(posedge clk);
        #1;
        idle();
        chk_state("badid", 2'd2, 2'd2, 1'b1);
        @(posedge clk);
        #1;
        chk_state("badid.sticky", 2'd2, 2'd2, 1'b1);

        // Reset in the middle of traffic with a flit on the link.
        do_reset();
        send_vld_i     = 1'b1;
        send_payload_i = 256'h11;
        send_vc_id_i   = 1'b0;
        @(posedge clk);
        #1;
        send_payload_i = 256'h22;
        @(posedge clk);
        #1;
        send_payload_i = 256'h33;
        send_vc_id_i   = 1'b1;
        @(posedge clk);
        #1;
        idle();
        chk("mid.fv_pre", pl_t'(flit_v_o), pl_t'(1'b1));
        chk("mid.data_pre", flit_o, 256'h33);
        chk_state("mid.pre", 2'd0, 2'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid.fv", pl_t'(flit_v_o), '0);
        chk("mid.data", flit_o, '0);
        chk_state("mid.rst", 2'd2, 2'd2, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/output_port_vc_tx.md
OUTPUT_PORT_VC_TX -- requirements
Module: output_port_vc_tx

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  - flit_payload_t, logic[256-1:0], flit data type.
  - VC_NUM, 1, downstream VC count.
  - VC_NUM_IDX_W, VC_NUM>1 ? $clog2(VC_NUM) : 1, VC index width.
  - VC_DEPTH, 1, downstream buffer slots (credits) per VC.
  - CRD_W, $clog2(VC_DEPTH+1), credit counter width.
REQ-002 SHALL have ports (name, direction, width, meaning):
  - clk, in, 1, sole clock, rising edge.
  - rst, in, 1, asynchronous active-high reset.
  - send_vld_i, in, 1, upstream offers flit.
  - send_payload_i, in, flit_payload_t, flit data.
  - send_dec_i, in, flit_dec_t, decoded flit ctrl.
  - send_vc_id_i, in, VC_NUM_IDX_W, target downstream VC.
  - send_rdy_o, out, 1, flit accepted this cycle if send_vld_i.
  - flit_v_o, out, 1, flit valid to link.
  - flit_o, out, flit_payload_t, link data.
  - flit_dec_o, out, flit_dec_t, link ctrl.
  - flit_vc_id_o, out, VC_NUM_IDX_W, link VC id.
  - lcrd_v_i, in, 1, credit returned by receiver.
  - lcrd_id_i, in, VC_ID_NUM_MAX_W, VC of returned credit.
  - vc_crd_avail_o, out, VC_NUM, per-VC credit nonzero.
  - vc_crd_cnt_o, out, VC_NUM x CRD_W, per-VC credit count.
  - all_crd_home_o, out, 1, every counter equals VC_DEPTH (link drained).
  - crd_err_o, out, 1, sticky protocol error.

Function
REQ-003 SHALL keep one credit counter per VC, range 0..VC_DEPTH.
REQ-004 send_rdy_o SHALL equal (cnt[send_vc_id_i] != 0) && (send_vc_id_i < VC_NUM), from registered state only, and SHALL NOT depend on send_vld_i or same-cycle lcrd_v_i.
REQ-005 Fire (send_vld_i && send_rdy_o) SHALL register payload, dec and vc_id to the link outputs with flit_v_o=1 on the next cycle (1-cycle latency).
REQ-006 With no fire, flit_v_o SHALL be 0 next cycle. Data outputs SHALL hold their last value.
REQ-007 On fire, cnt[send_vc_id_i] SHALL decrement by 1 at the next edge.
REQ-008 On lcrd_v_i with lcrd_id_i < VC_NUM, cnt[lcrd_id_i] SHALL increment by 1 at the next edge.
REQ-009 Fire and return on the same VC in one cycle SHALL leave that count unchanged. On different VCs, both updates SHALL apply.
REQ-010 A credit returned to a zero-count VC SHALL make send_rdy_o for that VC 1 from the next cycle (no same-cycle bypass).
REQ-011 A return that would exceed VC_DEPTH SHALL saturate the count at VC_DEPTH and set crd_err_o.
REQ-012 lcrd_id_i >= VC_NUM SHALL be ignored for counting and SHALL set crd_err_o.
REQ-013 crd_err_o SHALL remain set until reset.
REQ-014 vc_crd_avail_o, vc_crd_cnt_o and all_crd_home_o SHALL be derived from registered counters only.

Reset
REQ-015 On rst assertion, asynchronously:
  - every count SHALL become VC_DEPTH;
  - flit_v_o, crd_err_o and the data outputs SHALL become 0;
  - all_crd_home_o SHALL be 1;
  - vc_crd_avail_o SHALL be all ones.
REQ-016 Reset mid-operation SHALL discard any registered flit and restore full credits. The link partner is reset in the same domain.

Structure
REQ-017 flit_dec_t and VC_ID_NUM_MAX_W SHALL come from rvh_noc_pkg. No new package types are needed.
REQ-018 Per-VC counting SHALL use one sub-module vc_credit_counter (inc, dec, saturate, overflow flag), instantiated VC_NUM times.

Verification (VC_NUM=2, VC_DEPTH=2)
REQ-019 Post-reset state: cnt={2,2}, all_crd_home_o=1, flit_v_o=0, crd_err_o=0.
REQ-020 Drain VC0: send two flits on VC0 in back-to-back cycles -> flit_v_o=1 on cycles 1 and 2 with flit_vc_id_o=0; cnt[0]=0; third offer sees send_rdy_o=0.
REQ-021 Return on empty VC: with cnt[0]=0, apply lcrd_v_i on VC0 in cycle N -> send_rdy_o for VC0 is 0 in N and 1 in N+1; cnt[0]=1.
REQ-022 Same-VC fire and return: with cnt[1]=1, fire on VC1 and return on VC1 in the same cycle -> cnt[1] stays 1, flit emitted.
REQ-023 Overflow: with cnt[1]=2, return on VC1 -> cnt[1]=2, crd_err_o=1 and stays 1. Then lcrd_id_i=3 with err cleared by reset -> crd_err_o=1, counts unchanged.
REQ-024 Reset mid-operation: with cnt={0,1} and flit_v_o=1, assert rst -> cnt={2,2}, flit_v_o=0 immediately.
